// File: rtl/player_action_ctrl.sv
// player_action_ctrl
//   Per-player action generator fed by the keycode decoder. Four key levels
//   (A/S = P1 dive/kick, K/L = P2 dive/kick) are sampled on the frame tick,
//   optionally debounced, edge-detected, and resolved per player into one
//   action event (dive, kick, or the dive+kick "special" chord). Each event
//   is held under a valid/ack handshake until consumed.
//
//   Build option: INPUT_DEBOUNCE_EN
//     defined   - a level change needs DEBOUNCE_FRAMES consecutive
//                 disagreeing frame ticks.
//     undefined - levels are resampled on every frame tick; DEBOUNCE_FRAMES
//                 is ignored and no counters are built.
//
//   Ports
//     Clk, Reset                   clock, synchronous active-high reset
//     frame_tick                   one-cycle pulse per video frame
//     a_on, s_on, k_on, l_on       decoded key levels
//     p1_evt_ack, p2_evt_ack       consumer takes the pending event
//     p1_evt_valid, p2_evt_valid   event pending
//     p1_evt, p2_evt               01 dive, 10 kick, 11 special, 00 idle
//     p1_held, p2_held             debounced levels {kick, dive}

// One player's chord resolver. rise is {kick, dive}.
module player_action_fsm #(
    parameter int CHORD_FRAMES = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [1:0] rise,
    input  logic       evt_ack,
    output logic       evt_valid,
    output logic [1:0] evt
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHORD = 2'd1;
    localparam logic [1:0] ST_PEND  = 2'd2;
    localparam int WIN_W = (CHORD_FRAMES < 2) ? 1 : $clog2(CHORD_FRAMES + 1);

    logic [1:0]       state;
    logic [WIN_W-1:0] win;
    logic             first_kick;   // button that opened the chord window
    logic [1:0]       code;
    logic             partner_rise;

    assign partner_rise = first_kick ? rise[0] : rise[1];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            win        <= '0;
            first_kick <= 1'b0;
            code       <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise == 2'b11) begin
                        state <= ST_PEND;
                        code  <= 2'b11;
                    end else if (rise != 2'b00) begin
                        if (CHORD_FRAMES == 0) begin
                            state <= ST_PEND;
                            code  <= rise;
                        end else begin
                            state      <= ST_CHORD;
                            win        <= WIN_W'(CHORD_FRAMES);
                            first_kick <= rise[1];
                        end
                    end
                end
                ST_CHORD: begin
                    // Partner rise is checked first so it beats an expiring tick.
                    if (partner_rise) begin
                        state <= ST_PEND;
                        code  <= 2'b11;
                    end else if (frame_tick) begin
                        if (win == WIN_W'(1)) begin
                            state <= ST_PEND;
                            code  <= first_kick ? 2'b10 : 2'b01;
                        end else begin
                            win <= win - 1'b1;
                        end
                    end
                end
                ST_PEND: begin
                    if (evt_ack) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign evt_valid = (state == ST_PEND);
    assign evt       = evt_valid ? code : 2'b00;
endmodule

module player_action_ctrl #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int CHORD_FRAMES    = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       a_on,
    input  logic       s_on,
    input  logic       k_on,
    input  logic       l_on,
    input  logic       p1_evt_ack,
    input  logic       p2_evt_ack,
    output logic       p1_evt_valid,
    output logic       p2_evt_valid,
    output logic [1:0] p1_evt,
    output logic [1:0] p2_evt,
    output logic [1:0] p1_held,
    output logic [1:0] p2_held
);
    // Lane order {l, k, s, a}: bits [1:0] are P1 {kick, dive}, [3:2] are P2.
    logic [3:0]      raw, db, db_q, rise;
    logic [1:0]      ack, evt_valid;
    logic [1:0][1:0] evt;

    assign raw = {l_on, k_on, s_on, a_on};
    assign ack = {p2_evt_ack, p1_evt_ack};

`ifdef INPUT_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_FRAMES < 2) ? 1 : $clog2(DEBOUNCE_FRAMES + 1);
    logic [3:0][CNT_W-1:0] cnt;

    // cnt counts consecutive disagreeing ticks; it is cleared whenever the
    // raw level agrees again, so a glitch shorter than the threshold is lost.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            db  <= '0;
            cnt <= '0;
        end else if (frame_tick) begin
            for (int i = 0; i < 4; i++) begin
                if (raw[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                    db[i]  <= raw[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge Clk) begin
        if (Reset)           db <= '0;
        else if (frame_tick) db <= raw;
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) db_q <= '0;
        else       db_q <= db;
    end

    // Only presses matter; releases never generate an event.
    assign rise = db & ~db_q;

    for (genvar p = 0; p < 2; p++) begin : g_player
        player_action_fsm #(
            .CHORD_FRAMES(CHORD_FRAMES)
        ) u_fsm (
            .Clk       (Clk),
            .Reset     (Reset),
            .frame_tick(frame_tick),
            .rise      (rise[2*p+1 -: 2]),
            .evt_ack   (ack[p]),
            .evt_valid (evt_valid[p]),
            .evt       (evt[p])
        );
    end

    assign p1_evt_valid = evt_valid[0];
    assign p2_evt_valid = evt_valid[1];
    assign p1_evt       = evt[0];
    assign p2_evt       = evt[1];
    assign p1_held      = db[1:0];
    assign p2_held      = db[3:2];
endmodule

// File: tb/tb_player_action_ctrl.sv
module tb_player_action_ctrl;
    localparam int DF = 2;
    localparam int CH = 3;
`ifdef INPUT_DEBOUNCE_EN
    localparam int DB_LAT = DF;
`else
    localparam int DB_LAT = 1;
`endif

    logic       clk, rst, frame_tick;
    logic       a_on, s_on, k_on, l_on;
    logic       p1_evt_ack, p2_evt_ack;
    logic       p1_evt_valid, p2_evt_valid;
    logic [1:0] p1_evt, p2_evt, p1_held, p2_held;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    player_action_ctrl #(.DEBOUNCE_FRAMES(DF), .CHORD_FRAMES(CH)) dut (
        .Clk(clk), .Reset(rst), .frame_tick(frame_tick),
        .a_on(a_on), .s_on(s_on), .k_on(k_on), .l_on(l_on),
        .p1_evt_ack(p1_evt_ack), .p2_evt_ack(p2_evt_ack),
        .p1_evt_valid(p1_evt_valid), .p2_evt_valid(p2_evt_valid),
        .p1_evt(p1_evt), .p2_evt(p2_evt),
        .p1_held(p1_held), .p2_held(p2_held)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per key: stable level and length of the current run of disagreeing
    // ticks. Per player: pending code (0 = none), the lone button waiting for
    // its partner (0 = none, 1 dive, 2 kick) and ticks seen since it arrived.
    logic [3:0] m_db, m_prev;
    int m_run[4];
    int m_pend[2], m_first[2], m_seen[2];

    always @(posedge clk) begin : model
        logic [3:0] keys, pressed;
        logic [1:0] acks;
        int rp;
        keys = {l_on, k_on, s_on, a_on};
        acks = {p2_evt_ack, p1_evt_ack};
        if (rst) begin
            m_db = '0; m_prev = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            for (int p = 0; p < 2; p++) begin m_pend[p] = 0; m_first[p] = 0; m_seen[p] = 0; end
        end else begin
            pressed = m_db & ~m_prev;
            for (int p = 0; p < 2; p++) begin
                rp = int'(pressed[2*p +: 2]);
                if (m_pend[p] != 0) begin
                    if (acks[p]) m_pend[p] = 0;
                end else if (m_first[p] != 0) begin
                    if ((rp & (3 ^ m_first[p])) != 0) begin
                        m_pend[p] = 3; m_first[p] = 0;
                    end else if (frame_tick) begin
                        m_seen[p]++;
                        if (m_seen[p] == CH) begin m_pend[p] = m_first[p]; m_first[p] = 0; end
                    end
                end else if (rp == 3) begin
                    m_pend[p] = 3;
                end else if (rp != 0) begin
                    if (CH == 0) m_pend[p] = rp;
                    else begin m_first[p] = rp; m_seen[p] = 0; end
                end
            end
            m_prev = m_db;
            if (frame_tick) begin
                for (int i = 0; i < 4; i++) begin
`ifdef INPUT_DEBOUNCE_EN
                    if (keys[i] == m_db[i]) m_run[i] = 0;
                    else begin
                        m_run[i]++;
                        if (m_run[i] >= DF) begin m_db[i] = keys[i]; m_run[i] = 0; end
                    end
`else
                    m_db[i] = keys[i];
`endif
                end
            end
        end
    end

    // Compare every cycle once the DUT has been through reset.
    always @(negedge clk) begin
        if (chk_en)
            chk("model_cmp",
                {22'd0, p1_evt_valid, p1_evt, p1_held, p2_evt_valid, p2_evt, p2_held},
                {22'd0, m_pend[0] != 0, 2'(m_pend[0]), m_db[1:0],
                 m_pend[1] != 0, 2'(m_pend[1]), m_db[3:2]});
    end

    // ---------------- stimulus helpers ----------------
    // One frame = 4 cycles, tick in the first.
    task automatic frame();
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic wait_valid(input int p, input int max_frames);
        int f;
        f = 0;
        while (((p == 0) ? p1_evt_valid : p2_evt_valid) !== 1'b1 && f < max_frames) begin
            frame();
            f++;
        end
        chk($sformatf("p%0d_valid_wait", p + 1), (p == 0) ? p1_evt_valid : p2_evt_valid, 1);
    endtask

    task automatic ack(input int p);
        if (p == 0) p1_evt_ack = 1; else p2_evt_ack = 1;
        @(negedge clk);
        p1_evt_ack = 0; p2_evt_ack = 0;
        chk($sformatf("p%0d_valid_after_ack", p + 1), (p == 0) ? p1_evt_valid : p2_evt_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; frame_tick = 0;
        a_on = 0; s_on = 0; k_on = 0; l_on = 0;
        p1_evt_ack = 0; p2_evt_ack = 0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("reset_outputs", {p1_evt_valid, p1_evt, p1_held, p2_evt_valid, p2_evt, p2_held}, 0);

        // P1 single dive, held from reset release.
        rst = 0; a_on = 1;
        frames(DB_LAT);
        chk("p1_held_dive", p1_held, 2'b01);
        frames(CH - 1);
        chk("p1_valid_before_window", p1_evt_valid, 0);
        frame();
        chk("p1_valid_single", p1_evt_valid, 1);
        chk("p1_evt_single", p1_evt, 2'b01);
        ack(0);
        a_on = 0; frames(3);

        // P1 chord: S one tick after A -> special only.
        a_on = 1; frame(); s_on = 1;
        wait_valid(0, 8);
        chk("p1_evt_chord", p1_evt, 2'b11);
        ack(0);
        a_on = 0; s_on = 0; frames(3);

        // S arrives 4 ticks later: dive resolves alone, late S dropped in PEND.
        a_on = 1; frames(4); s_on = 1;
        wait_valid(0, 8);
        chk("p1_evt_late_partner", p1_evt, 2'b01);
        frames(3);
        chk("p1_evt_held_pend", p1_evt, 2'b01);
        ack(0);
        frames(5);
        chk("p1_no_second_evt", p1_evt_valid, 0);
        a_on = 0; s_on = 0; frames(3);

        // K glitch lasting exactly one tick.
        k_on = 1; frame_tick = 1;
        @(negedge clk);
        frame_tick = 0; k_on = 0;
`ifndef INPUT_DEBOUNCE_EN
        chk("p2_held_sample", p2_held, 2'b01);
`endif
        repeat (3) @(negedge clk);
`ifdef INPUT_DEBOUNCE_EN
        frames(5);
        chk("p2_glitch_held", p2_held, 2'b00);
        chk("p2_glitch_no_evt", p2_evt_valid, 0);
`else
        wait_valid(1, 6);
        chk("p2_evt_sample", p2_evt, 2'b01);
        ack(1);
`endif
        frames(2);

        // P2 same-cycle K+L: valid two cycles after the level update.
        k_on = 1; l_on = 1;
        frames(DB_LAT - 1);
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        chk("p2_held_both", p2_held, 2'b11);
        chk("p2_valid_rise_cycle", p2_evt_valid, 0);
        @(negedge clk);
        chk("p2_valid_special", p2_evt_valid, 1);
        chk("p2_evt_special", p2_evt, 2'b11);
        repeat (2) @(negedge clk);
        ack(1);
        k_on = 0; l_on = 0; frames(3);

        // Independence: A and L together, each player its own window.
        a_on = 1; l_on = 1;
        wait_valid(0, 8);
        chk("indep_p2_valid", p2_evt_valid, 1);
        chk("indep_p1_evt", p1_evt, 2'b01);
        chk("indep_p2_evt", p2_evt, 2'b10);
        ack(0);
        chk("indep_p2_still_valid", p2_evt_valid, 1);
        ack(1);
        a_on = 0; l_on = 0; frames(3);

        // Ack withheld 100 cycles while A is re-pressed.
        a_on = 1;
        wait_valid(0, 8);
        for (int f = 0; f < 25; f++) begin
            a_on = ((f >= 3 && f < 6) || (f >= 9 && f < 12));
            frame();
            chk("withheld_valid", p1_evt_valid, 1);
            chk("withheld_evt", p1_evt, 2'b01);
        end
        ack(0);
        frames(6);
        chk("withheld_dropped", p1_evt_valid, 0);

        // Reset in the middle of a chord window.
        a_on = 1;
        frames(DB_LAT + 1);
        rst = 1;
        @(negedge clk);
        chk("midreset_outputs", {p1_evt_valid, p1_evt, p1_held, p2_evt_valid, p2_evt, p2_held}, 0);
        rst = 0;
        wait_valid(0, 10);
        chk("midreset_fresh_evt", p1_evt, 2'b01);
        ack(0);
        a_on = 0; frames(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/player_action_ctrl.md
# player_action_ctrl

Per-player action generator that sits directly downstream of the keycode decoder. It consumes the four decoded key levels (A/S for player 1, K/L for player 2), debounces them on the frame tick and detects presses. It resolves each player's presses into one action event: dive, kick, or the dive+kick chord ("special"). Each event is held under a valid/ack handshake until the game-state logic consumes it.

## Interface
- DEBOUNCE_FRAMES, 2, consecutive frame ticks of disagreement required before a debounced level changes (≥1).
- CHORD_FRAMES, 3, frame ticks a single press waits for its partner button before resolving alone (0 = no window).
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame; pulses are ≥2 cycles apart.
- a_on, s_on, k_on, l_on  in  1 each  decoded key levels (A = P1 dive, S = P1 kick, K = P2 dive, L = P2 kick).
- p1_evt_ack, p2_evt_ack  in  1 each  consumer accepts the pending event.
- p1_evt_valid, p2_evt_valid  out  1 each  event pending.
- p1_evt, p2_evt  out  2 each  01 dive, 10 kick, 11 special; 00 when not valid.
- p1_held, p2_held  out  2 each  debounced levels, {kick, dive}.

## Operation
- **Debounce.** Debounce is per input. On frame_tick:
  - if raw == db, cnt←0;
  - else cnt←cnt+1;
  - when cnt+1 == DEBOUNCE_FRAMES, db←raw and cnt←0.
  - No change between ticks.
- **Edge detection.** rise = db & ~db_q, where db_q is db delayed one Clk. Only rises are used; releases produce no event.
- **FSM.** There is one identical, independent FSM per player, with states IDLE, CHORD, PEND.
  - IDLE:
    - both dive and kick rise in the same cycle → PEND, code 11;
    - one rises with CHORD_FRAMES=0 → PEND with that code;
    - one rises otherwise → CHORD, with win←CHORD_FRAMES and the first button remembered.
  - CHORD:
    - the other button rises → PEND, code 11;
    - else, on frame_tick with win==1 → PEND with the remembered single code;
    - else, on frame_tick → win←win−1.
    - A repeat rise of the remembered button is ignored.
    - If the partner rise and the expiring tick fall in the same cycle, special wins.
  - PEND: evt_valid=1 and evt is held stable. If ack=1 in a cycle, the next state is IDLE. Rises during PEND are dropped.
- ack is ignored when valid=0.
- **Reset.** Every register clears on reset: db, db_q, cnt, win, state=IDLE, remembered button. A key held through reset produces a fresh rise after DEBOUNCE_FRAMES ticks.

## Timing
- Reset values: p*_evt_valid=0, p*_evt=00, p*_held=00.
- Debounced level changes at the edge ending the DEBOUNCE_FRAMES-th consecutive disagreeing tick cycle.
- rise is high in the following cycle; the FSM state is visible one cycle after that.
- Single-press event: valid asserts one cycle after the CHORD_FRAMES-th frame tick following the rise.
- Special via same-cycle rise: valid asserts 2 cycles after db update.
- Ack: valid drops the cycle after the ack cycle. Back-to-back events are therefore separated by ≥1 idle cycle.
- The two player FSMs share only Clk, Reset and frame_tick, and never interact.

## Configuration
- INPUT_DEBOUNCE_EN defined: debounce behaves as above.
- INPUT_DEBOUNCE_EN undefined:
  - debounce counters are not built;
  - db←raw on every frame_tick, i.e. a one-tick sample;
  - DEBOUNCE_FRAMES is ignored.
- All other behaviour is identical.

## Test plan
Tests use DEBOUNCE_FRAMES=2 and CHORD_FRAMES=3, with INPUT_DEBOUNCE_EN defined unless stated.
- **P1 single dive.** a_on held from reset release.
  - p1_held=01 after tick 2.
  - p1_evt_valid=1, p1_evt=01 one cycle after the 3rd tick following the rise.
  - p1_evt_ack pulse → valid=0 next cycle.
- **P1 chord.** a_on rises, then s_on one tick later.
  - p1_evt=11 before window expiry, with no 01 event.
  - s_on 4 ticks later instead → 01 event only.
- **Glitch and P2 same-cycle special.**
  - k_on high for exactly 1 tick → no p2_held change, no event.
  - k_on and l_on rise in the same cycle → p2_evt=11.
- **Independence.** a_on and l_on pressed together → p1_evt=01 and p2_evt=10, each waiting its own window.
- **Ack withheld and reset mid-operation.**
  - With ack held 0 for 100 cycles: valid and evt stay stable, and extra a_on presses are dropped (one event only after ack).
  - Reset asserted mid-CHORD → valid=0, held=00, IDLE next cycle.
- **INPUT_DEBOUNCE_EN undefined.** k_on high for 1 tick → p2_held=01 at that tick, and p2_evt=01 after the window.
